// File: rtl/toggle_port_responder_pkg.sv
// Shared types for the toggle-handshake responder: FSM states, latched request, byte-select codes.
// Used by the top and by the optional write-coalescing buffer.
package toggle_port_pkg;

  localparam int TP_AW = 22;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_DONE
  } tp_state_t;

  typedef struct packed {
    logic             we;
    logic [TP_AW-1:0] addr;
    logic [1:0]       ds;
    logic [15:0]      din;
  } tp_req_t;

endpackage

// File: rtl/toggle_port_responder_if.sv
// Toggle-request host port plus strobed block-RAM backend bus; slave = responder view, master = host/backend view.
interface toggle_port_if #(
  parameter int AW = 22
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [1:0]    ds;
  logic [15:0]   din;
  logic [15:0]   dout;
  logic          ack;
  logic          overrun;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_be;
  logic [15:0]   mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [15:0]   mem_dout;

  modport slave (
    input  req, we, addr, ds, din, mem_dout,
    output dout, ack, overrun, mem_addr, mem_be, mem_din, mem_we, mem_rd
  );

  modport master (
    output req, we, addr, ds, din, mem_dout,
    input  dout, ack, overrun, mem_addr, mem_be, mem_din, mem_we, mem_rd
  );
endinterface

// File: rtl/toggle_port_responder_coalesce_buf.sv
// One-entry low-byte write buffer (exists only with TOGGLE_PORT_COALESCE_EN); merge/flush decisions are combinational.
// Holds until the responder clears it on a merge or flush; it never stalls the host by itself.
`ifdef TOGGLE_PORT_COALESCE_EN
module tp_coalesce_buf
  import toggle_port_pkg::*;
(
  input  logic             clk_sys,
  input  logic             res_n,
  input  tp_req_t          cur_i,
  input  logic             load_i,
  input  logic             clr_i,
  output logic             flush_o,
  output logic             merge_o,
  output logic [TP_AW-1:0] addr_o,
  output logic [15:0]      flush_dat_o,
  output logic [15:0]      merge_dat_o
);

  logic             vld_q, vld_d;
  logic [TP_AW-1:0] addr_q, addr_d;
  logic [7:0]       lo_q, lo_d;

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      lo_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      lo_q   <= lo_d;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    lo_d   = lo_q;
    if (clr_i) vld_d = 1'b0;
    if (load_i) begin
      vld_d  = 1'b1;
      addr_d = cur_i.addr;
      lo_d   = cur_i.din[7:0];
    end
  end

  // Only a high-byte write to the buffered word may merge; everything else evicts the buffer first.
  assign merge_o     = vld_q && cur_i.we && (cur_i.ds == DS_HI) && (cur_i.addr == addr_q);
  assign flush_o     = vld_q && !merge_o;
  assign addr_o      = addr_q;
  assign flush_dat_o = {8'h00, lo_q};
  assign merge_dat_o = {cur_i.din[15:8], lo_q};

endmodule
`endif

// File: rtl/toggle_port_responder.sv
// Toggle-handshake responder to a strobed RAM bus: write acks 3 edges after req flips, read 2+READ_LATENCY.
// No backpressure: a req flip while busy sets sticky overrun. TOGGLE_PORT_COALESCE_EN adds low-byte write merging.
module toggle_port_responder
  import toggle_port_pkg::*;
#(
  parameter int AW           = TP_AW,
  parameter int READ_LATENCY = 1
) (
  input  logic         clk_sys,
  input  logic         res_n,
  toggle_port_if.slave tp
);

  tp_state_t   state_q, state_d;
  tp_req_t     lat_q, lat_d;
  tp_req_t     cur;
  logic        req_lat_q, req_lat_d;
  logic        req_prev_q;
  logic        ack_q, ack_d;
  logic [15:0] dout_q, dout_d;
  logic        overrun_q, overrun_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_rd_q, mem_rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        take;

  assign cur = '{we: tp.we, addr: tp.addr, ds: tp.ds, din: tp.din};

`ifdef TOGGLE_PORT_COALESCE_EN
  logic             cb_flush, cb_merge, cb_load, cb_clr;
  logic [TP_AW-1:0] cb_addr;
  logic [15:0]      cb_flush_dat, cb_merge_dat;

  tp_coalesce_buf u_coalesce (
    .clk_sys     (clk_sys),
    .res_n       (res_n),
    .cur_i       (cur),
    .load_i      (cb_load),
    .clr_i       (cb_clr),
    .flush_o     (cb_flush),
    .merge_o     (cb_merge),
    .addr_o      (cb_addr),
    .flush_dat_o (cb_flush_dat),
    .merge_dat_o (cb_merge_dat)
  );
`endif

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      req_lat_q  <= 1'b0;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      dout_q     <= '0;
      overrun_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      req_lat_q  <= req_lat_d;
      req_prev_q <= tp.req;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      overrun_q  <= overrun_d;
      mem_we_q   <= mem_we_d;
      mem_rd_q   <= mem_rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    req_lat_d = req_lat_q;
    ack_d     = ack_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q | ((state_q != ST_IDLE) && (tp.req != req_prev_q));
    mem_we_d  = 1'b0;
    mem_rd_d  = 1'b0;
    take      = 1'b0;
`ifdef TOGGLE_PORT_COALESCE_EN
    cb_load   = 1'b0;
    cb_clr    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (tp.req != ack_q) begin
          take = 1'b1;
`ifdef TOGGLE_PORT_COALESCE_EN
          // A flush borrows the backend word register and stays in IDLE; the request is taken next edge.
          if (cb_flush) begin
            take     = 1'b0;
            cb_clr   = 1'b1;
            mem_we_d = 1'b1;
            lat_d    = '{we: 1'b1, addr: cb_addr, ds: DS_LO, din: cb_flush_dat};
          end else if (cb_merge) begin
            take      = 1'b0;
            cb_clr    = 1'b1;
            mem_we_d  = 1'b1;
            req_lat_d = tp.req;
            lat_d     = '{we: 1'b1, addr: cur.addr, ds: DS_BOTH, din: cb_merge_dat};
            state_d   = ST_WRITE;
          end else if (cur.we && (cur.ds == DS_LO)) begin
            take      = 1'b0;
            cb_load   = 1'b1;
            req_lat_d = tp.req;
            lat_d     = cur;
            state_d   = ST_DONE;
          end
`endif
          if (take) begin
            lat_d     = cur;
            req_lat_d = tp.req;
            if (cur.we) begin
              mem_we_d = (cur.ds != 2'b00);
              state_d  = ST_WRITE;
            end else begin
              mem_rd_d = 1'b1;
              cnt_d    = '0;
              state_d  = ST_READ_WAIT;
            end
          end
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_READ_WAIT: begin
        if (cnt_q == 2'(READ_LATENCY - 1)) state_d = ST_DONE;
        else cnt_d = cnt_q + 2'd1;
      end
      ST_DONE: begin
        // Backend data is valid on this edge, so read data and ack update together.
        ack_d = req_lat_q;
        if (!lat_q.we) dout_d = tp.mem_dout;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tp.ack      = ack_q;
  assign tp.dout     = dout_q;
  assign tp.overrun  = overrun_q;
  assign tp.mem_we   = mem_we_q;
  assign tp.mem_rd   = mem_rd_q;
  assign tp.mem_addr = lat_q.addr[AW-1:0];
  assign tp.mem_be   = lat_q.ds;
  assign tp.mem_din  = lat_q.din;

endmodule

// File: tb/tb_toggle_port_responder.sv
// Scoreboard bench for toggle_port_responder (READ_LATENCY=3); expectations follow TOGGLE_PORT_COALESCE_EN.
module tb_toggle_port_responder;

  localparam int AW = 22;
  localparam int RL = 3;
`ifdef TOGGLE_PORT_COALESCE_EN
  localparam int LO_W_LAT = 2;
  localparam int FLUSH    = 1;
`else
  localparam int LO_W_LAT = 3;
  localparam int FLUSH    = 0;
`endif

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [1:0]    be;
    logic [15:0]   d;
  } strb_t;

  typedef struct {
    logic        ack;
    logic [15:0] dout;
    int          cyc;
  } done_t;

  logic clk_sys = 1'b0;
  logic res_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic ack_prev = 1'b0;
  strb_t exp_s[$];
  done_t exp_d[$];

  logic [15:0] mem  [0:63] = '{default: 16'h0000};
  logic [15:0] pipe [0:RL-1] = '{default: 16'h0000};

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  toggle_port_if #(.AW(AW)) tp ();

  toggle_port_responder #(.AW(AW), .READ_LATENCY(RL)) dut (
    .clk_sys (clk_sys),
    .res_n   (res_n),
    .tp      (tp)
  );

  // Backend RAM: data read at the mem_rd sample edge emerges RL edges later; garbage otherwise.
  always @(posedge clk_sys) begin
    if (tp.mem_we) begin
      if (tp.mem_be[0]) mem[tp.mem_addr[5:0]][7:0]  <= tp.mem_din[7:0];
      if (tp.mem_be[1]) mem[tp.mem_addr[5:0]][15:8] <= tp.mem_din[15:8];
    end
    pipe[0] <= tp.mem_rd ? mem[tp.mem_addr[5:0]] : 16'hDEAD;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign tp.mem_dout = pipe[RL-1];

  always @(negedge clk_sys) begin : monitor
    strb_t s;
    done_t d;
    if (mon_en) begin
      if (tp.mem_we || tp.mem_rd) begin
        checks++;
        if (exp_s.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: we=%0b rd=%0b addr=%h be=%b din=%h at cyc %0d",
                   tp.mem_we, tp.mem_rd, tp.mem_addr, tp.mem_be, tp.mem_din, cyc);
        end else begin
          s = exp_s.pop_front();
          if (tp.mem_we !== s.w || tp.mem_rd !== !s.w || tp.mem_addr !== s.a ||
              (s.w && (tp.mem_be !== s.be || tp.mem_din !== s.d))) begin
            errors++;
            $display("FAIL strobe: got we=%0b rd=%0b addr=%h be=%b din=%h, expected we=%0b addr=%h be=%b din=%h",
                     tp.mem_we, tp.mem_rd, tp.mem_addr, tp.mem_be, tp.mem_din, s.w, s.a, s.be, s.d);
          end
        end
      end
      if (tp.ack !== ack_prev) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: ack=%0b dout=%h at cyc %0d", tp.ack, tp.dout, cyc);
        end else begin
          d = exp_d.pop_front();
          if (tp.ack !== d.ack || tp.dout !== d.dout || cyc != d.cyc) begin
            errors++;
            $display("FAIL completion: got ack=%0b dout=%h cyc=%0d, expected ack=%0b dout=%h cyc=%0d",
                     tp.ack, tp.dout, cyc, d.ack, d.dout, d.cyc);
          end
        end
      end
      ack_prev = tp.ack;
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [1:0] d,
                       input logic [15:0] di, output int c);
    tp.we   = w;
    tp.addr = a;
    tp.ds   = d;
    tp.din  = di;
    tp.req  = ~tp.req;
    c       = cyc;
  endtask

  task automatic exp_w(input logic [AW-1:0] a, input logic [1:0] be, input logic [15:0] d);
    exp_s.push_back('{w: 1'b1, a: a, be: be, d: d});
  endtask

  task automatic exp_r(input logic [AW-1:0] a);
    exp_s.push_back('{w: 1'b0, a: a, be: 2'b00, d: 16'h0000});
  endtask

  task automatic exp_done(input logic dout_ack, input logic [15:0] dout, input int at);
    exp_d.push_back('{ack: dout_ack, dout: dout, cyc: at});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (tp.ack !== tp.req && n < 20) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    checks++;
    if (tp.ack !== tp.req) begin
      errors++;
      $display("FAIL %s_timeout: ack=%0b req=%0b after %0d cycles", name, tp.ack, tp.req, n);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    res_n   = 1'b0;
    tp.req  = 1'b0;
    tp.we   = 1'b0;
    tp.addr = '0;
    tp.ds   = 2'b00;
    tp.din  = 16'h0000;
    cycles(3);
    chk("reset_outputs", 64'({tp.ack, tp.overrun, tp.mem_we, tp.mem_rd, tp.mem_be,
                              tp.dout, tp.mem_din, tp.mem_addr}), 64'h0);
    res_n = 1'b1;
    ack_prev = 1'b0;
    mon_en = 1'b1;
    cycles(2);

    issue(1'b1, 22'h000010, 2'b11, 16'hBEEF, c);
    exp_w(22'h10, 2'b11, 16'hBEEF); exp_done(1'b1, 16'h0000, c + 3);
    wait_done("write_full");

    issue(1'b0, 22'h000010, 2'b11, 16'h0000, c);
    exp_r(22'h10); exp_done(1'b0, 16'hBEEF, c + 2 + RL);
    wait_done("read_full");

    issue(1'b1, 22'h000009, 2'b11, 16'h1357, c);
    exp_w(22'h09, 2'b11, 16'h1357); exp_done(1'b1, 16'hBEEF, c + 3);
    wait_done("write_9");

    // Lone low-byte write then a read elsewhere: the write reaches the backend before the read.
    issue(1'b1, 22'h000007, 2'b01, 16'h0056, c);
    exp_w(22'h07, 2'b01, 16'h0056); exp_done(1'b0, 16'hBEEF, c + LO_W_LAT);
    wait_done("write_lo_7");
    issue(1'b0, 22'h000009, 2'b11, 16'h0000, c);
    exp_r(22'h09); exp_done(1'b1, 16'h1357, c + 2 + RL + FLUSH);
    wait_done("read_9");
    issue(1'b0, 22'h000007, 2'b11, 16'h0000, c);
    exp_r(22'h07); exp_done(1'b0, 16'h0056, c + 2 + RL);
    wait_done("read_7");

    issue(1'b1, 22'h000030, 2'b00, 16'hFFFF, c);
    exp_done(1'b1, 16'h0056, c + 3);
    wait_done("write_ds00");
    issue(1'b0, 22'h000030, 2'b00, 16'h0000, c);
    exp_r(22'h30); exp_done(1'b0, 16'h0000, c + 2 + RL);
    wait_done("read_ds00");

    chk("overrun_clear", 64'(tp.overrun), 64'h0);
    issue(1'b1, 22'h000040, 2'b11, 16'h4444, c);
    exp_w(22'h40, 2'b11, 16'h4444); exp_done(1'b1, 16'h0000, c + 3);
    cycles(1); tp.req = ~tp.req;
    cycles(1); tp.req = ~tp.req;
    cycles(6);
    chk("overrun_set", 64'(tp.overrun), 64'h1);
    chk("overrun_ack_eq_req", 64'(tp.ack), 64'(tp.req));

    issue(1'b1, 22'h000005, 2'b01, 16'h1212, c);
`ifndef TOGGLE_PORT_COALESCE_EN
    exp_w(22'h05, 2'b01, 16'h1212);
`endif
    exp_done(tp.req, 16'h0000, c + LO_W_LAT);
    wait_done("byte_lo_5");
    issue(1'b1, 22'h000005, 2'b10, 16'h3434, c);
`ifdef TOGGLE_PORT_COALESCE_EN
    exp_w(22'h05, 2'b11, 16'h3412);
`else
    exp_w(22'h05, 2'b10, 16'h3434);
`endif
    exp_done(tp.req, 16'h0000, c + 3);
    wait_done("byte_hi_5");
    issue(1'b0, 22'h000005, 2'b11, 16'h0000, c);
    exp_r(22'h05); exp_done(tp.req, 16'h3412, c + 2 + RL);
    wait_done("read_5");
    chk("overrun_sticky", 64'(tp.overrun), 64'h1);

    // Reset in READ_WAIT: outputs clear at once and the aborted read never completes.
    issue(1'b0, 22'h000010, 2'b11, 16'h0000, c);
    exp_r(22'h10);
    cycles(2);
    mon_en = 1'b0;
    res_n  = 1'b0;
    #1;
    chk("midreset_outputs", 64'({tp.ack, tp.overrun, tp.mem_we, tp.mem_rd, tp.mem_be,
                                 tp.dout, tp.mem_din, tp.mem_addr}), 64'h0);
    tp.req = 1'b0;
    cycles(2);
    res_n = 1'b1;
    ack_prev = 1'b0;
    mon_en = 1'b1;
    cycles(8);
    chk("midreset_no_late_ack", 64'(tp.ack), 64'h0);

    // Reset released with req=1 is a request on the first edge.
    mon_en  = 1'b0;
    res_n   = 1'b0;
    tp.we   = 1'b1;
    tp.addr = 22'h000020;
    tp.ds   = 2'b11;
    tp.din  = 16'h2020;
    tp.req  = 1'b1;
    cycles(1);
    res_n = 1'b1;
    c = cyc;
    ack_prev = 1'b0;
    mon_en = 1'b1;
    exp_w(22'h20, 2'b11, 16'h2020); exp_done(1'b1, 16'h0000, c + 3);
    wait_done("release_req_high");
    chk("release_overrun_clear", 64'(tp.overrun), 64'h0);

    cycles(4);
    chk("strobe_queue_empty", 64'(exp_s.size()), 64'h0);
    chk("done_queue_empty", 64'(exp_d.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
